// File: rtl/pipe_stage_skid_pkg.sv
// Shared definitions for the pipeline stage register: reset PC, default lane
// field widths and the skid FSM state encoding.
package pipe_stage_skid_pkg;

   localparam logic [31:0] PC_RST_VEC = 32'hbfc00000;
   localparam int          DATA_W_DEF = 32;
   localparam int          ADDR_W_DEF = 5;
   localparam int          PC_W_DEF   = 32;

   // Encoding doubles as the occupancy count.
   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      FULL  = 2'd2
   } state_t;

endpackage

// File: rtl/pipe_stage_skid_if.sv
// Handshake bundle between two pipeline stages. The master drives the input
// beat and consumes the output; the slave is the stage register itself.
interface pipe_stage_skid_if
   import pipe_stage_skid_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int PC_W   = PC_W_DEF,
   parameter int LANES  = 1
);
   logic                      in_valid;
   logic                      in_ready;
   logic [LANES*DATA_W-1:0]   in_wdata;
   logic [LANES*ADDR_W-1:0]   in_waddr;
   logic [LANES-1:0]          in_wen;
   logic [PC_W-1:0]           in_pc;
   logic                      out_valid;
   logic                      out_ready;
   logic [LANES*DATA_W-1:0]   out_wdata;
   logic [LANES*ADDR_W-1:0]   out_waddr;
   logic [LANES-1:0]          out_wen;
   logic [PC_W-1:0]           out_pc;
   logic [1:0]                occupancy;

   modport master (
      output in_valid, in_wdata, in_waddr, in_wen, in_pc, out_ready,
      input  in_ready, out_valid, out_wdata, out_waddr, out_wen, out_pc, occupancy
   );

   modport slave (
      input  in_valid, in_wdata, in_waddr, in_wen, in_pc, out_ready,
      output in_ready, out_valid, out_wdata, out_waddr, out_wen, out_pc, occupancy
   );

endinterface

// File: rtl/pipe_beat_reg.sv
// One payload register (all lanes plus PC). Clear returns it to the empty
// pattern (zero data, PC_RST) and wins over load so a flush can never leave a
// partially updated beat behind.
module pipe_beat_reg
   import pipe_stage_skid_pkg::*;
#(
   parameter int              DATA_W = DATA_W_DEF,
   parameter int              ADDR_W = ADDR_W_DEF,
   parameter int              PC_W   = PC_W_DEF,
   parameter int              LANES  = 1,
   parameter logic [PC_W-1:0] PC_RST = PC_W'(PC_RST_VEC)
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    clr,
   input  logic                    ld,
   input  logic [LANES*DATA_W-1:0] d_wdata,
   input  logic [LANES*ADDR_W-1:0] d_waddr,
   input  logic [LANES-1:0]        d_wen,
   input  logic [PC_W-1:0]         d_pc,
   output logic [LANES*DATA_W-1:0] q_wdata,
   output logic [LANES*ADDR_W-1:0] q_waddr,
   output logic [LANES-1:0]        q_wen,
   output logic [PC_W-1:0]         q_pc
);

   // Payload register: reset/clear to the bubble pattern, else load on demand.
   always_ff @(posedge clk) begin
      if (rst || clr) begin
         q_wdata <= '0;
         q_waddr <= '0;
         q_wen   <= '0;
         q_pc    <= PC_RST;
      end else if (ld) begin
         q_wdata <= d_wdata;
         q_waddr <= d_waddr;
         q_wen   <= d_wen;
         q_pc    <= d_pc;
      end
   end

endmodule

// File: rtl/pipe_stage_skid.sv
// Parametrised pipeline stage register with valid/ready handshake. SKID=1
// adds a second payload register so in_ready comes straight from a flop;
// SKID=0 is a single register with combinational in_ready.
module pipe_stage_skid
   import pipe_stage_skid_pkg::*;
#(
   parameter int              DATA_W = DATA_W_DEF,
   parameter int              ADDR_W = ADDR_W_DEF,
   parameter int              PC_W   = PC_W_DEF,
   parameter int              LANES  = 1,
   parameter logic [PC_W-1:0] PC_RST = PC_W'(PC_RST_VEC),
   parameter bit              SKID   = 1'b1
) (
   input logic               clk,
   input logic               rst,
   input logic               flush,
   pipe_stage_skid_if.slave  bus
);

   logic                    push, pop, vld, in_ready_w;
   logic                    main_ld, main_clr;
   logic [1:0]              occ;
   logic [LANES*DATA_W-1:0] main_d_wdata, main_wdata;
   logic [LANES*ADDR_W-1:0] main_d_waddr, main_waddr;
   logic [LANES-1:0]        main_d_wen, main_wen;
   logic [PC_W-1:0]         main_d_pc, main_pc;

   assign push = bus.in_valid & in_ready_w;
   assign pop  = vld & bus.out_ready;

   pipe_beat_reg #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .PC_W(PC_W), .LANES(LANES), .PC_RST(PC_RST)) u_main (
      .clk(clk), .rst(rst), .clr(main_clr), .ld(main_ld),
      .d_wdata(main_d_wdata), .d_waddr(main_d_waddr), .d_wen(main_d_wen), .d_pc(main_d_pc),
      .q_wdata(main_wdata), .q_waddr(main_waddr), .q_wen(main_wen), .q_pc(main_pc)
   );

   if (SKID) begin : g_skid
      state_t                  state, state_nxt;
      logic                    rdy_q, skid_ld, skid_clr, main_from_skid;
      logic [LANES*DATA_W-1:0] skid_wdata;
      logic [LANES*ADDR_W-1:0] skid_waddr;
      logic [LANES-1:0]        skid_wen;
      logic [PC_W-1:0]         skid_pc;

      pipe_beat_reg #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .PC_W(PC_W), .LANES(LANES), .PC_RST(PC_RST)) u_skid (
         .clk(clk), .rst(rst), .clr(skid_clr), .ld(skid_ld),
         .d_wdata(bus.in_wdata), .d_waddr(bus.in_waddr), .d_wen(bus.in_wen), .d_pc(bus.in_pc),
         .q_wdata(skid_wdata), .q_waddr(skid_waddr), .q_wen(skid_wen), .q_pc(skid_pc)
      );

      assign main_d_wdata = main_from_skid ? skid_wdata : bus.in_wdata;
      assign main_d_waddr = main_from_skid ? skid_waddr : bus.in_waddr;
      assign main_d_wen   = main_from_skid ? skid_wen   : bus.in_wen;
      assign main_d_pc    = main_from_skid ? skid_pc    : bus.in_pc;

      // Next-state and register steering; flush empties both registers and drops any push.
      always_comb begin
         state_nxt      = state;
         main_ld        = 1'b0;
         main_clr       = 1'b0;
         main_from_skid = 1'b0;
         skid_ld        = 1'b0;
         skid_clr       = 1'b0;
         if (flush) begin
            state_nxt = EMPTY;
            main_clr  = 1'b1;
            skid_clr  = 1'b1;
         end else begin
            case (state)
               EMPTY: if (push) begin
                  main_ld   = 1'b1;
                  state_nxt = ONE;
               end
               ONE: begin
                  if (push && pop) begin
                     main_ld = 1'b1;
                  end else if (push) begin
                     skid_ld   = 1'b1;
                     state_nxt = FULL;
                  end else if (pop) begin
                     main_clr  = 1'b1;
                     state_nxt = EMPTY;
                  end
               end
               FULL: if (pop) begin
                  main_ld        = 1'b1;
                  main_from_skid = 1'b1;
                  skid_clr       = 1'b1;
                  state_nxt      = ONE;
               end
               default: begin
                  state_nxt = EMPTY;
                  main_clr  = 1'b1;
                  skid_clr  = 1'b1;
               end
            endcase
         end
      end

      // State register; in_ready is registered from the next state and held low through reset.
      always_ff @(posedge clk) begin
         if (rst) begin
            state <= EMPTY;
            rdy_q <= 1'b0;
         end else begin
            state <= state_nxt;
            rdy_q <= (state_nxt != FULL);
         end
      end

      assign vld        = (state != EMPTY);
      assign in_ready_w = rdy_q;
      assign occ        = state;
   end else begin : g_noskid
      logic vld_q;

      assign main_d_wdata = bus.in_wdata;
      assign main_d_waddr = bus.in_waddr;
      assign main_d_wen   = bus.in_wen;
      assign main_d_pc    = bus.in_pc;
      assign in_ready_w   = !vld_q | bus.out_ready;

      // Load on push; clear on flush or when the held beat leaves with nothing behind it.
      always_comb begin
         main_ld  = 1'b0;
         main_clr = 1'b0;
         main_ld  = push & !flush;
         main_clr = flush | (pop & !push);
      end

      // Valid flag tracking the single register.
      always_ff @(posedge clk) begin
         if (rst || flush)
            vld_q <= 1'b0;
         else if (push)
            vld_q <= 1'b1;
         else if (pop)
            vld_q <= 1'b0;
      end

      assign vld = vld_q;
      assign occ = {1'b0, vld_q};
   end

   for (genvar i = 0; i < LANES; i++) begin : g_lane
      assign bus.out_wdata[i*DATA_W +: DATA_W] = main_wdata[i*DATA_W +: DATA_W];
      assign bus.out_waddr[i*ADDR_W +: ADDR_W] = main_waddr[i*ADDR_W +: ADDR_W];
      assign bus.out_wen[i]                    = main_wen[i] & vld;
   end

   assign bus.out_valid = vld;
   assign bus.out_pc    = vld ? main_pc : PC_RST;
   assign bus.in_ready  = in_ready_w;
   assign bus.occupancy = occ;

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Directed bench for pipe_stage_skid: a SKID=1 instance checked against a
// FIFO scoreboard plus directed probes, and a SKID=0 instance with a few
// directed probes of the combinational ready path.
module tb_pipe_stage_skid;
   localparam int DW = 32, AW = 5, PW = 32, L = 2;
   localparam logic [31:0] PCR = 32'hbfc00000;

   typedef struct packed {
      logic [L*DW-1:0] wdata;
      logic [L*AW-1:0] waddr;
      logic [L-1:0]    wen;
      logic [PW-1:0]   pc;
   } beat_t;

   logic clk = 1'b0, rst, flush1, flush0, mon_en;
   int   checks = 0, failures = 0, pops = 0;
   beat_t sb[$];

   always #5 clk = ~clk;

   pipe_stage_skid_if #(.DATA_W(DW), .ADDR_W(AW), .PC_W(PW), .LANES(L)) b1 ();
   pipe_stage_skid_if #(.DATA_W(DW), .ADDR_W(AW), .PC_W(PW), .LANES(L)) b0 ();

   pipe_stage_skid #(.DATA_W(DW), .ADDR_W(AW), .PC_W(PW), .LANES(L), .PC_RST(PCR), .SKID(1'b1))
      dut1 (.clk(clk), .rst(rst), .flush(flush1), .bus(b1));
   pipe_stage_skid #(.DATA_W(DW), .ADDR_W(AW), .PC_W(PW), .LANES(L), .PC_RST(PCR), .SKID(1'b0))
      dut0 (.clk(clk), .rst(rst), .flush(flush0), .bus(b0));

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic beat_t mk(input logic [31:0] pc);
      beat_t b;
      b.wdata = {~pc, pc ^ 32'h5a5a_a5a5};
      b.waddr = {pc[8:4], pc[6:2]};
      b.wen   = pc[3:2];
      b.pc    = pc;
      return b;
   endfunction

   task automatic put1(input logic v, input beat_t b);
      b1.in_valid = v; b1.in_wdata = b.wdata; b1.in_waddr = b.waddr;
      b1.in_wen = b.wen; b1.in_pc = b.pc;
   endtask

   task automatic put0(input logic v, input beat_t b);
      b0.in_valid = v; b0.in_wdata = b.wdata; b0.in_waddr = b.waddr;
      b0.in_wen = b.wen; b0.in_pc = b.pc;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Scoreboard on the SKID=1 instance: pop/compare on handshake, push accepted beats, check bubbles.
   always @(negedge clk) begin : mon
      beat_t got, e;
      if (mon_en) begin
         got = {b1.out_wdata, b1.out_waddr, b1.out_wen, b1.out_pc};
         if (b1.out_valid === 1'b1 && b1.out_ready === 1'b1 && !rst) begin
            pops++;
            chk("pop_nonempty", 128'(sb.size() != 0), 128'(1));
            if (sb.size() != 0) begin
               e = sb.pop_front();
               chk("pop_beat", 128'(got), 128'(e));
            end
         end
         if (b1.out_valid === 1'b0)
            chk("bubble", 128'({b1.out_wen, b1.out_wdata, b1.out_waddr, b1.out_pc}), 128'({76'd0, PCR}));
         if (rst || flush1)
            sb.delete();
         else if (b1.in_valid === 1'b1 && b1.in_ready === 1'b1)
            sb.push_back({b1.in_wdata, b1.in_waddr, b1.in_wen, b1.in_pc});
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      beat_t x, idle;
      int p0;
      idle = '0;
      rst = 1'b1; flush1 = 1'b0; flush0 = 1'b0; mon_en = 1'b0;
      put1(1'b0, idle); put0(1'b0, idle);
      b1.out_ready = 1'b0; b0.out_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0; mon_en = 1'b1;
      tick();
      chk("rst_in_ready", 128'(b1.in_ready), 128'(1));
      chk("rst_out_valid", 128'(b1.out_valid), 128'(0));
      chk("rst_out_wen", 128'(b1.out_wen), 128'(0));
      chk("rst_out_pc", 128'(b1.out_pc), 128'(PCR));
      chk("rst_occ", 128'(b1.occupancy), 128'(0));
      chk("rst0_in_ready", 128'(b0.in_ready), 128'(1));
      chk("rst0_out_pc", 128'(b0.out_pc), 128'(PCR));

      // single beat, lane 1 disabled but still carrying data
      x.wdata = {32'h8765_4321, 32'h1234_5678}; x.waddr = {5'd9, 5'd3};
      x.wen = 2'b01; x.pc = 32'hbfc00010;
      b1.out_ready = 1'b1; put1(1'b1, x); tick(); put1(1'b0, idle);
      chk("one_valid", 128'(b1.out_valid), 128'(1));
      chk("one_occ", 128'(b1.occupancy), 128'(1));
      chk("one_wen", 128'(b1.out_wen), 128'(2'b01));
      chk("one_pc", 128'(b1.out_pc), 128'(32'hbfc00010));
      chk("one_wdata", 128'(b1.out_wdata), 128'({32'h8765_4321, 32'h1234_5678}));
      tick();
      chk("one_drained", 128'(b1.out_valid), 128'(0));

      // fill skid with A,B under backpressure, then drain
      b1.out_ready = 1'b0;
      put1(1'b1, mk(32'h100)); tick();
      put1(1'b1, mk(32'h104)); tick(); put1(1'b0, idle);
      chk("full_occ", 128'(b1.occupancy), 128'(2));
      chk("full_in_ready", 128'(b1.in_ready), 128'(0));
      chk("full_pc_a", 128'(b1.out_pc), 128'(32'h100));
      tick();
      chk("hold_pc_a", 128'(b1.out_pc), 128'(32'h100));
      chk("hold_occ", 128'(b1.occupancy), 128'(2));
      b1.out_ready = 1'b1; tick();
      chk("after_a_in_ready", 128'(b1.in_ready), 128'(1));
      chk("after_a_pc_b", 128'(b1.out_pc), 128'(32'h104));
      chk("after_a_occ", 128'(b1.occupancy), 128'(1));
      tick();
      chk("drain_occ", 128'(b1.occupancy), 128'(0));

      // streaming: 100 back-to-back beats
      p0 = pops;
      for (int i = 0; i < 100; i++) begin
         put1(1'b1, mk(32'h1000 + 32'(i) * 4));
         chk("stream_rdy", 128'(b1.in_ready), 128'(1));
         tick();
      end
      put1(1'b0, idle); tick();
      chk("stream_pops", 128'(pops - p0), 128'(100));
      chk("stream_sb_empty", 128'(sb.size()), 128'(0));

      // flush from FULL with in_valid high
      b1.out_ready = 1'b0;
      put1(1'b1, mk(32'h200)); tick();
      put1(1'b1, mk(32'h204)); tick();
      chk("pre_flush_occ", 128'(b1.occupancy), 128'(2));
      flush1 = 1'b1; put1(1'b1, mk(32'h2e0)); tick();
      flush1 = 1'b0; put1(1'b0, idle);
      chk("flush_occ", 128'(b1.occupancy), 128'(0));
      chk("flush_valid", 128'(b1.out_valid), 128'(0));
      chk("flush_wen", 128'(b1.out_wen), 128'(0));
      chk("flush_pc", 128'(b1.out_pc), 128'(PCR));
      chk("flush_in_ready", 128'(b1.in_ready), 128'(1));
      p0 = pops; b1.out_ready = 1'b1;
      repeat (3) tick();
      chk("flush_no_pop", 128'(pops - p0), 128'(0));

      // flush from ONE with an accepted-looking push
      b1.out_ready = 1'b0;
      put1(1'b1, mk(32'h300)); tick();
      flush1 = 1'b1; put1(1'b1, mk(32'h304)); tick();
      flush1 = 1'b0; put1(1'b0, idle);
      chk("flush1_occ", 128'(b1.occupancy), 128'(0));
      p0 = pops; b1.out_ready = 1'b1;
      repeat (2) tick();
      chk("flush1_no_pop", 128'(pops - p0), 128'(0));

      // two bubble cycles between beats
      put1(1'b1, mk(32'h408)); tick(); put1(1'b0, idle);
      chk("bub_first", 128'(b1.out_valid), 128'(1));
      for (int i = 0; i < 2; i++) begin
         tick();
         chk("bub_valid", 128'(b1.out_valid), 128'(0));
         chk("bub_fields", 128'({b1.out_wen, b1.out_wdata, b1.out_waddr}), 128'(0));
      end
      put1(1'b1, mk(32'h40c)); tick(); put1(1'b0, idle);
      chk("bub_second_pc", 128'(b1.out_pc), 128'(32'h40c));
      tick();

      // reset while holding a beat
      b1.out_ready = 1'b0;
      put1(1'b1, mk(32'h500)); tick(); put1(1'b0, idle);
      rst = 1'b1; tick(); rst = 1'b0;
      chk("rst_mid_occ", 128'(b1.occupancy), 128'(0));
      chk("rst_mid_pc", 128'(b1.out_pc), 128'(PCR));
      tick();
      chk("rst_mid_in_ready", 128'(b1.in_ready), 128'(1));

      // SKID=0: combinational ready
      put0(1'b1, mk(32'h600)); tick(); put0(1'b0, idle);
      chk("s0_valid", 128'(b0.out_valid), 128'(1));
      chk("s0_occ", 128'(b0.occupancy), 128'(1));
      chk("s0_in_ready_stall", 128'(b0.in_ready), 128'(0));
      chk("s0_beat", 128'({b0.out_wdata, b0.out_waddr, b0.out_wen, b0.out_pc}), 128'(mk(32'h600)));
      b0.out_ready = 1'b1; #1;
      chk("s0_in_ready_comb", 128'(b0.in_ready), 128'(1));
      tick();
      chk("s0_empty_valid", 128'(b0.out_valid), 128'(0));
      chk("s0_empty_pc", 128'(b0.out_pc), 128'(PCR));
      chk("s0_empty_wdata", 128'(b0.out_wdata), 128'(0));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
